// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access unit: op and state
// encodings, bus widths, and the byte-enable / store-replication / alignment
// rules used when a request is accepted.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mau_state_e;

  // Stores are the three highest encodings.
  function automatic logic op_is_store(input mem_op_e op);
    logic res;
    case (op)
      OP_SB, OP_SH, OP_SW: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

  // Halfwords must sit on an even address, words on a multiple of four.
  function automatic logic op_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic res;
    case (op)
      OP_LH, OP_LHU, OP_SH: res = addr_lo[0];
      OP_LW, OP_SW:         res = (addr_lo != 2'b00);
      default:              res = 1'b0;
    endcase
    return res;
  endfunction

  // Byte-lane enables for an (assumed aligned) access.
  function automatic logic [BE_W-1:0] op_byte_en(input mem_op_e op, input logic [1:0] addr_lo);
    logic [BE_W-1:0] res;
    case (op)
      OP_LB, OP_LBU, OP_SB: res = 4'b0001 << addr_lo;
      OP_LH, OP_LHU, OP_SH: res = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:              res = 4'b1111;
    endcase
    return res;
  endfunction

  // Replicate the right-justified store data into every lane it may land in;
  // loads drive no write data.
  function automatic logic [DATA_W-1:0] op_store_data(input mem_op_e op, input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] res;
    case (op)
      OP_SB:   res = {4{wdata[7:0]}};
      OP_SH:   res = {2{wdata[15:0]}};
      OP_SW:   res = wdata;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it according to the load op.
module load_ext
  import mem_pkg::*;
(
  input  mem_op_e           op_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection by the low address bits.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
  end

  // Extension of the selected lane to a full register value.
  always_comb begin
    data_o = 32'h0000_0000;
    case (op_i)
      OP_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  data_o = {24'h00_0000, byte_s};
      OP_LH:   data_o = {{16{half_s[15]}}, half_s};
      OP_LHU:  data_o = {16'h0000, half_s};
      OP_LW:   data_o = word_i;
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory access unit. Accepts one load/store at a time, stalls
// the pipeline while it owns the memory port, and returns a single-cycle
// response carrying the extended load data or a misalignment exception.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_exc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  mau_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              misalign_q, misalign_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  mem_op_e           req_op_s;
  logic [DATA_W-1:0] ext_data_s;
  logic              in_req_s;
  logic              in_wait_s;
  logic              in_resp_s;

  assign req_op_s = mem_op_e'(req_op);

  load_ext u_load_ext (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .word_i    (mem_rdata),
    .data_o    (ext_data_s)
  );

  // State and transaction registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LB;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      be_q       <= 4'b0000;
      misalign_q <= 1'b0;
      rdata_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      misalign_q <= misalign_d;
      rdata_q    <= rdata_d;
    end
  end

  // Next-state logic and request capture.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    misalign_d = misalign_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d       = req_op_s;
          addr_d     = req_addr;
          wdata_d    = op_store_data(req_op_s, req_wdata);
          be_d       = op_byte_en(req_op_s, req_addr[1:0]);
          misalign_d = op_misaligned(req_op_s, req_addr[1:0]);
          // Stores and exceptions respond with zero data.
          rdata_d    = 32'h0000_0000;
          if (op_misaligned(req_op_s, req_addr[1:0])) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          if (op_is_store(op_q)) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ext_data_s;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_req_s  = (state_q == ST_REQ);
  assign in_wait_s = (state_q == ST_WAIT);
  assign in_resp_s = (state_q == ST_RESP);

  // Outputs decoded from registered state; memory strobes are quiet outside REQ.
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    stall     = (req_valid & ~req_ready) | in_req_s | in_wait_s;
    rsp_valid = in_resp_s;
    rsp_exc   = in_resp_s & misalign_q;
    if (in_resp_s) begin
      rsp_rdata = rdata_q;
    end else begin
      rsp_rdata = 32'h0000_0000;
    end
    mem_req  = in_req_s;
    mem_we   = in_req_s & op_is_store(op_q);
    mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (in_req_s) begin
      mem_be    = be_q;
      mem_wdata = wdata_q;
    end else begin
      mem_be    = 4'b0000;
      mem_wdata = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors plus randomized
// transactions, each checked cycle by cycle against a transaction-level model.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_exc;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          g;     // extra REQ cycles before grant
    int          r;     // extra WAIT cycles before rvalid
    bit          hold;  // keep req_valid high for the next transaction
  } txn_t;

  txn_t tq[$];

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_exc    (rsp_exc),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic int acc_size(input int op);
    case (op)
      0, 1, 5: return 1;
      2, 3, 6: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_store(input int op);
    return op >= 5;
  endfunction

  function automatic bit is_mis(input int op, input logic [31:0] addr);
    return (int'(addr[1:0]) % acc_size(op)) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input int op, input logic [31:0] addr);
    int m;
    m = ((1 << acc_size(op)) - 1) << int'(addr[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] w);
    case (acc_size(op))
      1:       return {24'h0, w[7:0]} * 32'h0101_0101;
      2:       return {16'h0, w[15:0]} * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input int op, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] s;
    logic [31:0] v;
    s = w >> (8 * int'(addr[1:0]));
    case (acc_size(op))
      1: begin
        v = s & 32'h0000_00FF;
        if (op == 0 && s[7]) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = s & 32'h0000_FFFF;
        if (op == 2 && s[15]) v = v | 32'hFFFF_0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  // ---- one transaction, driven and checked cycle by cycle ---------------
  task automatic run_txn(input int idx, input txn_t t, input bit hold, input txn_t nx);
    bit          mis;
    bit          st;
    int          last;
    bit          in_req;
    bit          in_wait;
    logic [31:0] rsp;
    string       p;
    mis = is_mis(t.op, t.addr);
    st  = is_store(t.op);
    if (mis)     last = 1;
    else if (st) last = 2 + t.g;
    else         last = 3 + t.g + t.r;
    rsp = (!mis && !st) ? exp_load(t.op, t.addr, t.rword) : 32'h0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      in_req  = !mis && k >= 1 && k <= 1 + t.g;
      in_wait = !mis && !st && k >= 2 + t.g && k <= 2 + t.g + t.r;
      if (k == 0) begin
        req_valid = 1'b1;
        req_op    = 3'(t.op);
        req_addr  = t.addr;
        req_wdata = t.wdata;
      end else if (hold) begin
        req_valid = 1'b1;
        req_op    = 3'(nx.op);
        req_addr  = nx.addr;
        req_wdata = nx.wdata;
      end else begin
        req_valid = 1'b0;
        req_op    = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
      mem_gnt = (!mis && k == 1 + t.g);
      if (in_wait) begin
        mem_rvalid = (k == 2 + t.g + t.r);
        mem_rdata  = mem_rvalid ? t.rword : $urandom;
      end else begin
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
      end
      #1;
      p = $sformatf("t%0d c%0d", idx, k);
      check_eq({p, " req_ready"}, 32'(req_ready), 32'(k == 0));
      check_eq({p, " stall"}, 32'(stall), 32'((k != 0) && (hold || in_req || in_wait)));
      check_eq({p, " rsp_valid"}, 32'(rsp_valid), 32'(k == last));
      check_eq({p, " rsp_exc"}, 32'(rsp_exc), 32'(k == last && mis));
      check_eq({p, " rsp_rdata"}, rsp_rdata, (k == last) ? rsp : 32'h0);
      check_eq({p, " mem_req"}, 32'(mem_req), 32'(in_req));
      check_eq({p, " mem_we"}, 32'(mem_we), 32'(in_req && st));
      check_eq({p, " mem_be"}, 32'(mem_be), in_req ? 32'(exp_be(t.op, t.addr)) : 32'h0);
      check_eq({p, " mem_wdata"}, mem_wdata, (in_req && st) ? exp_wdata(t.op, t.wdata) : 32'h0);
      if (in_req) check_eq({p, " mem_addr"}, mem_addr, {t.addr[31:2], 2'b00});
    end
  endtask

  // Everything quiet and ready, as after reset.
  task automatic check_idle(input string tag);
    check_eq({tag, " req_ready"}, 32'(req_ready), 32'h1);
    check_eq({tag, " stall"}, 32'(stall), 32'h0);
    check_eq({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, " rsp_exc"}, 32'(rsp_exc), 32'h0);
    check_eq({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, " mem_req"}, 32'(mem_req), 32'h0);
    check_eq({tag, " mem_we"}, 32'(mem_we), 32'h0);
    check_eq({tag, " mem_be"}, 32'(mem_be), 32'h0);
    check_eq({tag, " mem_wdata"}, mem_wdata, 32'h0);
    check_eq({tag, " mem_addr"}, mem_addr, 32'h0);
  endtask

  function automatic txn_t mk(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rword, input int g, input int r, input bit hold);
    txn_t t;
    t.op = op; t.addr = addr; t.wdata = wdata; t.rword = rword;
    t.g = g; t.r = r; t.hold = hold;
    return t;
  endfunction

  initial begin
    txn_t t;
    txn_t nx;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    // Directed vectors.
    tq.push_back(mk(5, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 1'b0));
    tq.push_back(mk(0, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 0, 1'b0));
    tq.push_back(mk(1, 32'h0000_2002, 32'h0, 32'h1280_3456, 0, 0, 1'b0));
    tq.push_back(mk(2, 32'h0000_2002, 32'h0, 32'h8001_0000, 0, 0, 1'b0));
    tq.push_back(mk(4, 32'h0000_2002, 32'h0, 32'h0, 0, 0, 1'b0));
    tq.push_back(mk(7, 32'hDEAD_BEE0, 32'h1234_5678, 32'h0, 3, 0, 1'b0));
    tq.push_back(mk(6, 32'h0000_0402, 32'h0000_C3D4, 32'h0, 1, 0, 1'b1));
    tq.push_back(mk(3, 32'h0000_0402, 32'h0, 32'hF00D_8765, 2, 2, 1'b1));
    tq.push_back(mk(6, 32'h0000_0401, 32'h0, 32'h0, 0, 0, 1'b0));
    // Randomized transactions.
    for (int i = 0; i < 80; i++) begin
      tq.push_back(mk($urandom_range(0, 7), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < tq.size(); i++) begin
      t  = tq[i];
      nx = (i + 1 < tq.size()) ? tq[i + 1] : tq[i];
      run_txn(i, t, t.hold && (i + 1 < tq.size()), nx);
    end

    // Reset during WAIT with a coincident and a late rvalid.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_3000; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check_eq("wait stall", 32'(stall), 32'h1);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_1111;
    #1;
    check_idle("rst_wait c1");
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_idle("rst_wait c2");

    // Reset coincident with an incoming misaligned request.
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h0000_0001;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    #1;
    check_idle("rst_req");

    // Reset in REQ coincident with the grant.
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h0000_0040; req_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_eq("rst_gnt mem_req", 32'(mem_req), 32'h1);
    reset = 1'b1; mem_gnt = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_gnt = 1'b0;
    #1;
    check_idle("rst_gnt c1");
    @(negedge clk);
    #1;
    check_idle("rst_gnt c2");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
